dmem_responder: RTL

Multi-cycle data-memory responder that answers the CPU-side D-memory request port (chip select, write enable, word address, byte enables, write data) and produces read data with a fixed, parameterised latency. It sits below the L1 data cache as the backing store. It drives a BUSY level that the pipeline uses as its freeze source, and an ACK pulse that marks response completion. Writes are byte-lane masked; reads always return a full word.

---
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: CPU-side D-memory request/response bundle.
// The master (CPU / testbench) drives the request fields; the slave
// (dmem_responder) returns read data, busy level, ack pulse and range error.
interface dmem_responder_if;
  logic        csn;   // chip select, active-low
  logic        req;   // request strobe
  logic        wen;   // write enable, active-low (0 = write, 1 = read)
  logic [11:0] addr;  // word address
  logic [3:0]  be;    // byte enables
  logic [31:0] di;    // write data
  logic [31:0] dout;  // read data
  logic        busy;  // high whenever the responder is not idle
  logic        ack;   // one-cycle completion pulse
  logic        err;   // range error, valid with ack

  modport master (
    output csn, req, wen, addr, be, di,
    input  dout, busy, ack, err
  );

  modport slave (
    input  csn, req, wen, addr, be, di,
    output dout, busy, ack, err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory backing store below the L1 D-cache.
// A request is accepted in IDLE or RESP, waits LATENCY edges, then completes
// in a one-cycle RESP state that pulses ack. Writes are byte-lane masked and
// reads return a full word that dout holds until the next read response.
// Optional feature macro: DMEM_RANGE_CHECK_EN -- when defined, addresses with
// any bit set above DEPTH_LOG2 are flagged with err and have no storage effect
// (reads return 0); when undefined, addresses wrap and err is tied 0.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_responder_if.slave bus
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Merge new write data into an existing word, lane by lane.
  function automatic logic [31:0] merge_lanes(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  lane_en
  );
    logic [31:0] result;
    for (int i = 0; i < 4; i++) begin
      result[8*i +: 8] = lane_en[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return result;
  endfunction

`ifdef DMEM_RANGE_CHECK_EN
  // True when any address bit above the storage depth is set.
  function automatic logic out_of_range(input logic [11:0] word_addr);
    logic [11:0] high_mask;
    high_mask = ~((12'd1 << DEPTH_LOG2) - 12'd1);
    return |(word_addr & high_mask);
  endfunction
`endif

  // Storage array; deliberately not cleared by reset.
  logic [31:0] mem [DEPTH];

  state_t                  state_r;
  state_t                  state_s;
  logic [3:0]              cnt_r;
  logic [3:0]              cnt_s;
  logic [DEPTH_LOG2-1:0]   idx_r;
  logic [3:0]              be_r;
  logic [31:0]             di_r;
  logic                    wen_r;
  logic                    oor_r;
  logic [31:0]             dout_r;
  logic                    ack_r;
  logic                    err_r;
  logic                    busy_r;
  logic                    accept_s;
  logic                    in_oor_s;
  logic                    resp_entry_s;
  logic                    mem_we_s;
  logic                    rd_load_s;

  // Range classification of the incoming address.
`ifdef DMEM_RANGE_CHECK_EN
  assign in_oor_s = out_of_range(bus.addr);
`else
  assign in_oor_s = 1'b0;
`endif

  // Accept decode: a strobed, selected request while IDLE or RESP.
  always_comb begin
    accept_s = 1'b0;
    if (bus.req && !bus.csn && (state_r == ST_IDLE || state_r == ST_RESP)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Next-state and latency counter. The counter is loaded with LATENCY-1 at
  // accept and RESP is entered on the edge that finds it at zero, which puts
  // RESP entry exactly LATENCY edges after the accept edge for every legal
  // LATENCY (LATENCY=1 spends its single cycle in WAIT with the counter at 0).
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE, ST_RESP: begin
        if (accept_s) begin
          state_s = ST_WAIT;
          cnt_s   = CNT_LOAD;
        end else begin
          state_s = ST_IDLE;
          cnt_s   = cnt_r;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_RESP;
          cnt_s   = cnt_r;
        end else begin
          state_s = ST_WAIT;
          cnt_s   = cnt_r - 4'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Response-edge actions, all taken from the captured request.
  always_comb begin
    resp_entry_s = (state_s == ST_RESP);
    mem_we_s     = 1'b0;
    rd_load_s    = 1'b0;
    if (resp_entry_s) begin
      mem_we_s  = !wen_r && !oor_r;
      rd_load_s = wen_r;
    end else begin
      mem_we_s  = 1'b0;
      rd_load_s = 1'b0;
    end
  end

  // State, counter and request capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      idx_r   <= '0;
      be_r    <= 4'd0;
      di_r    <= 32'd0;
      wen_r   <= 1'b1;
      oor_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        idx_r <= bus.addr[DEPTH_LOG2-1:0];
        be_r  <= bus.be;
        di_r  <= bus.di;
        wen_r <= bus.wen;
        oor_r <= in_oor_s;
      end
    end
  end

  // Masked write into the array on the RESP-entry edge.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[idx_r] <= merge_lanes(mem[idx_r], di_r, be_r);
    end
  end

  // Registered outputs: read data, ack pulse, range error and busy level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r <= 32'd0;
      ack_r  <= 1'b0;
      err_r  <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      if (rd_load_s) begin
        dout_r <= oor_r ? 32'd0 : mem[idx_r];
      end
      ack_r  <= resp_entry_s;
      err_r  <= resp_entry_s && oor_r;
      busy_r <= (state_s != ST_IDLE);
    end
  end

  assign bus.dout = dout_r;
  assign bus.ack  = ack_r;
  assign bus.err  = err_r;
  assign bus.busy = busy_r;

endmodule
